rbm_batch_sequencer: RTL and testbench
======================================

Name: rbm_batch_sequencer

Overview:
Batch controller that runs a sequence of IMAGE_NUM images through one RBM inference core (Main-style: reset, data_valid, packed output, finish). Per image it pulses the core reset, raises data_valid, waits for finish, captures the packed class scores and computes the argmax sequentially. It compares the argmax with the supplied label and accumulates an accuracy count. It sits between the image/label store and the RBM core and replaces hand-driven single-image sequencing.

Parameters:
BITLENGTH, 12, width of one class score (signed two's complement)
OUTPUT_DIM, 10, number of class scores in the packed core output
CLASS_W, 4, width of class index; must satisfy 2^CLASS_W > OUTPUT_DIM
IMAGE_NUM, 100, images per batch (≥1)
INDEX_W, 16, width of image index and counters
RESET_CYCLES, 2, cycles core reset is held per image (≥1)
TIMEOUT, 65535, max cycles in RUN before the image is abandoned

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  begin batch; sampled only in IDLE
img_index  output  INDEX_W  index of current image for the image store
img_valid  input  1  image store has presented data/label for img_index
img_label  input  CLASS_W  ground-truth class of current image
rbm_reset  output  1  reset to RBM core
rbm_data_valid  output  1  data_valid to RBM core
rbm_finish  input  1  finish from RBM core (level, may stay high)
rbm_output  input  OUTPUT_DIM*BITLENGTH  packed scores, element k at bits [k*BITLENGTH +: BITLENGTH]
pred_valid  output  1  one-cycle strobe, prediction available
pred_class  output  CLASS_W  argmax class; all-ones on timeout
pred_correct  output  1  pred_class == img_label (0 on timeout)
correct_count  output  INDEX_W  correct predictions this batch
timeout_flag  output  1  sticky; set if any image timed out in this batch
busy  output  1  high in every state except IDLE and DONE
done  output  1  high in DONE until next start or reset

Behaviour:
- Reset values: all outputs 0, except rbm_reset=1 (core held in reset while idle). FSM→IDLE.
- States: IDLE → LOAD → CORE_RST → RUN → ARGMAX → REPORT → (LOAD | DONE).
- IDLE: start=1 → clear correct_count, timeout_flag, img_index; go LOAD next cycle.
- LOAD: wait img_valid=1; latch img_label; go CORE_RST. img_index stable from LOAD through REPORT.
- CORE_RST: rbm_reset=1 exactly RESET_CYCLES cycles, rbm_data_valid=0; then RUN.
- RUN: rbm_reset=0, rbm_data_valid=1. Detect rbm_finish rising edge (registered previous value; previous cleared in CORE_RST so a stuck-high finish counts as an edge exactly once). On edge: capture rbm_output into internal register, go ARGMAX. Cycle counter; reaching TIMEOUT without edge → set timeout_flag, pred_class=all-ones, pred_correct=0, go REPORT.
- ARGMAX: one element per cycle, k=0..OUTPUT_DIM-1, OUTPUT_DIM cycles total. Signed compare, replace only on strictly greater → ties resolve to lowest index. Then REPORT.
- REPORT: rbm_data_valid=0, rbm_reset=1; pred_valid=1 for exactly one cycle with pred_class/pred_correct; correct_count increments if correct. pred_class/pred_correct hold until the next REPORT. If img_index==IMAGE_NUM-1 → DONE else img_index+1, LOAD.
- Latency finish-edge→pred_valid: OUTPUT_DIM+1 cycles.
- DONE: done=1, busy=0, rbm_reset=1; start=1 → behaves as IDLE start (new batch).
- start while busy: ignored. img_valid outside LOAD: ignored. rbm_finish outside RUN: ignored.
- correct_count saturates at 2^INDEX_W-1.
- Async reset mid-batch: immediate return to reset values; no partial pred_valid.

Test Plan:
- IMAGE_NUM=3, core model returns scores with max at class 7, labels 7,7,2 → three pred_valid strobes, pred_class=7 each, pred_correct 1,1,0, correct_count=2, done=1.
- Scores {5,-3,9,9,0,...} (BITLENGTH=12) → pred_class=2 (tie to lowest); all scores -2048 except k=9 at -1 → pred_class=9 (signed compare).
- rbm_finish held high continuously from before RUN → exactly one capture per image; no double-count across 3 images.
- TIMEOUT=50, core never finishes on image 1 → after 50 RUN cycles pred_valid with pred_class=15, pred_correct=0, timeout_flag=1; image 2 proceeds normally.
- img_valid withheld 20 cycles in LOAD → rbm_reset remains 1, no CORE_RST until img_valid; RESET_CYCLES=2 verified by rbm_reset high exactly 2 cycles before data_valid rises.
- Assert reset during ARGMAX of image 2 → all outputs to reset values that cycle, no pred_valid; new start reruns from img_index=0.

Source files
------------

// File: rtl/rbm_batch_sequencer.sv
// Batch sequencer for one RBM inference core: per image it resets the core, runs it,
// captures the packed class scores, takes a sequential signed argmax and scores accuracy.
module rbm_batch_sequencer #(
  parameter int BITLENGTH    = 12,
  parameter int OUTPUT_DIM   = 10,
  parameter int CLASS_W      = 4,
  parameter int IMAGE_NUM    = 100,
  parameter int INDEX_W      = 16,
  parameter int RESET_CYCLES = 2,
  parameter int TIMEOUT      = 65535
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  output logic [INDEX_W-1:0]              img_index,
  input  logic                            img_valid,
  input  logic [CLASS_W-1:0]              img_label,
  output logic                            rbm_reset,
  output logic                            rbm_data_valid,
  input  logic                            rbm_finish,
  input  logic [OUTPUT_DIM*BITLENGTH-1:0] rbm_output,
  output logic                            pred_valid,
  output logic [CLASS_W-1:0]              pred_class,
  output logic                            pred_correct,
  output logic [INDEX_W-1:0]              correct_count,
  output logic                            timeout_flag,
  output logic                            busy,
  output logic                            done
);

  // One shared counter serves the core-reset hold, the run timeout and the argmax walk.
  localparam int CNT_MAX = (TIMEOUT > OUTPUT_DIM)
                         ? ((TIMEOUT > RESET_CYCLES) ? TIMEOUT : RESET_CYCLES)
                         : ((OUTPUT_DIM > RESET_CYCLES) ? OUTPUT_DIM : RESET_CYCLES);
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   RST_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   ARG_LAST = CNT_W'(OUTPUT_DIM - 1);
  localparam logic [INDEX_W-1:0] IMG_LAST = INDEX_W'(IMAGE_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CORE_RST, S_RUN, S_ARGMAX, S_REPORT, S_DONE
  } state_t;

  state_t                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            fin_prev_q, fin_prev_d;
  logic [OUTPUT_DIM*BITLENGTH-1:0] scores_q, scores_d;
  logic signed [BITLENGTH-1:0]     best_val_q, best_val_d;
  logic [CLASS_W-1:0]              best_idx_q, best_idx_d;
  logic [CLASS_W-1:0]              label_q, label_d;
  logic [INDEX_W-1:0]              img_index_q, img_index_d;
  logic [CLASS_W-1:0]              pred_class_q, pred_class_d;
  logic                            pred_correct_q, pred_correct_d;
  logic [INDEX_W-1:0]              correct_count_q, correct_count_d;
  logic                            timeout_q, timeout_d;

  logic                            fin_edge;
  logic signed [BITLENGTH-1:0]     cur_score;
  logic                            take;
  logic [CLASS_W-1:0]              final_idx;

  // The captured vector shifts down one element per argmax cycle, so element k sits at the bottom on step k.
  assign fin_edge  = rbm_finish & ~fin_prev_q;
  assign cur_score = signed'(scores_q[BITLENGTH-1:0]);
  assign take      = (cnt_q == '0) || (cur_score > best_val_q);
  assign final_idx = take ? CLASS_W'(cnt_q) : best_idx_q;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q + 1'b1;
    fin_prev_d      = 1'b0;
    scores_d        = scores_q;
    best_val_d      = best_val_q;
    best_idx_d      = best_idx_q;
    label_d         = label_q;
    img_index_d     = img_index_q;
    pred_class_d    = pred_class_q;
    pred_correct_d  = pred_correct_q;
    correct_count_d = correct_count_q;
    timeout_d       = timeout_q;
    rbm_reset       = 1'b1;
    rbm_data_valid  = 1'b0;
    pred_valid      = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        cnt_d = '0;
        if (start) begin
          img_index_d     = '0;
          correct_count_d = '0;
          timeout_d       = 1'b0;
          state_d         = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d = '0;
        if (img_valid) begin
          label_d = img_label;
          state_d = S_CORE_RST;
        end
      end
      S_CORE_RST: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        rbm_reset      = 1'b0;
        rbm_data_valid = 1'b1;
        fin_prev_d     = rbm_finish;
        if (fin_edge) begin
          scores_d = rbm_output;
          cnt_d    = '0;
          state_d  = S_ARGMAX;
        end else if (cnt_q == TO_LAST) begin
          pred_class_d   = '1;
          pred_correct_d = 1'b0;
          timeout_d      = 1'b1;
          state_d        = S_REPORT;
        end
      end
      S_ARGMAX: begin
        rbm_reset      = 1'b0;
        rbm_data_valid = 1'b1;
        scores_d       = scores_q >> BITLENGTH;
        if (take) begin
          best_val_d = cur_score;
          best_idx_d = CLASS_W'(cnt_q);
        end
        if (cnt_q == ARG_LAST) begin
          pred_class_d   = final_idx;
          pred_correct_d = (final_idx == label_q);
          if ((final_idx == label_q) && (correct_count_q != '1))
            correct_count_d = correct_count_q + 1'b1;
          state_d = S_REPORT;
        end
      end
      S_REPORT: begin
        pred_valid = 1'b1;
        cnt_d      = '0;
        if (img_index_q == IMG_LAST) begin
          state_d = S_DONE;
        end else begin
          img_index_d = img_index_q + 1'b1;
          state_d     = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      fin_prev_q      <= 1'b0;
      scores_q        <= '0;
      best_val_q      <= '0;
      best_idx_q      <= '0;
      label_q         <= '0;
      img_index_q     <= '0;
      pred_class_q    <= '0;
      pred_correct_q  <= 1'b0;
      correct_count_q <= '0;
      timeout_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      fin_prev_q      <= fin_prev_d;
      scores_q        <= scores_d;
      best_val_q      <= best_val_d;
      best_idx_q      <= best_idx_d;
      label_q         <= label_d;
      img_index_q     <= img_index_d;
      pred_class_q    <= pred_class_d;
      pred_correct_q  <= pred_correct_d;
      correct_count_q <= correct_count_d;
      timeout_q       <= timeout_d;
    end
  end

  assign img_index     = img_index_q;
  assign pred_class    = pred_class_q;
  assign pred_correct  = pred_correct_q;
  assign correct_count = correct_count_q;
  assign timeout_flag  = timeout_q;
  assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done          = (state_q == S_DONE);

endmodule

// File: tb/tb_rbm_batch_sequencer.sv
// Bench for rbm_batch_sequencer: a behavioural RBM core and image store drive the DUT,
// a queue of per-image expectations derived from the score tables is checked on every strobe.
module tb_rbm_batch_sequencer;

  localparam int BL = 12;
  localparam int OD = 10;
  localparam int CW = 4;
  localparam int IN = 3;
  localparam int IW = 16;
  localparam int RC = 2;
  localparam int TO = 50;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic [IW-1:0]      img_index;
  logic               img_valid = 1'b0;
  logic [CW-1:0]      img_label = '0;
  logic               rbm_reset;
  logic               rbm_data_valid;
  logic               rbm_finish = 1'b0;
  logic [OD*BL-1:0]   rbm_output = '0;
  logic               pred_valid;
  logic [CW-1:0]      pred_class;
  logic               pred_correct;
  logic [IW-1:0]      correct_count;
  logic               timeout_flag;
  logic               busy;
  logic               done;

  rbm_batch_sequencer #(
    .BITLENGTH(BL), .OUTPUT_DIM(OD), .CLASS_W(CW), .IMAGE_NUM(IN),
    .INDEX_W(IW), .RESET_CYCLES(RC), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .img_index(img_index),
    .img_valid(img_valid), .img_label(img_label), .rbm_reset(rbm_reset),
    .rbm_data_valid(rbm_data_valid), .rbm_finish(rbm_finish), .rbm_output(rbm_output),
    .pred_valid(pred_valid), .pred_class(pred_class), .pred_correct(pred_correct),
    .correct_count(correct_count), .timeout_flag(timeout_flag), .busy(busy), .done(done)
  );

  initial forever #5 clock = ~clock;

  // Image store and core behaviour knobs.
  int           scores [IN][OD];
  logic [CW-1:0] labels [IN];
  bit           never_fin [IN];
  int           lat = 5;
  bit           stuck = 1'b0;
  bit           store_en = 1'b1;

  typedef struct {
    logic [CW-1:0] cls;
    logic          correct;
    logic [IW-1:0] count;
    logic          tflag;
    logic [IW-1:0] idx;
    bit            timed_out;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int   cyc = 0, dv_cnt = 0, edge_cyc = 0, pv_total = 0;
  bit   edge_seen = 1'b0, pv_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  function automatic int model_argmax(input int i);
    int best = 0;
    for (int k = 1; k < OD; k++)
      if (scores[i][k] > scores[i][best]) best = k;
    return best;
  endfunction

  task automatic build_expect();
    logic [IW-1:0] count = '0;
    logic          tflag = 1'b0;
    exp_t          e;
    exp_q.delete();
    for (int i = 0; i < IN; i++) begin
      e.timed_out = never_fin[i];
      if (never_fin[i]) begin
        e.cls     = '1;
        e.correct = 1'b0;
        tflag     = 1'b1;
      end else begin
        e.cls     = CW'(model_argmax(i));
        e.correct = (e.cls == labels[i]);
      end
      if (e.correct && count != '1) count = count + 1'b1;
      e.count = count;
      e.tflag = tflag;
      e.idx   = IW'(i);
      exp_q.push_back(e);
    end
  endtask

  // Core and image-store model, driven just after each rising edge.
  initial begin
    int i;
    int run_cnt = 0;
    forever begin
      @(posedge clock);
      #2;
      i = (int'(img_index) < IN) ? int'(img_index) : 0;
      for (int k = 0; k < OD; k++) rbm_output[k*BL +: BL] = BL'(scores[i][k]);
      img_label = labels[i];
      img_valid = store_en;
      if (rbm_reset) begin
        run_cnt    = 0;
        rbm_finish = stuck;
      end else if (rbm_data_valid) begin
        run_cnt++;
        if (!never_fin[i] && run_cnt >= lat) rbm_finish = 1'b1;
      end
    end
  end

  // Compare process: every strobe is matched against the expectation queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      cyc++;
      if (pred_valid) begin
        pv_total++;
        check("pred_single_cycle", 32'(pv_prev), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pred_valid: got strobe at img_index %0d expected none", img_index);
        end else begin
          e = exp_q.pop_front();
          check("pred_class", 32'(pred_class), 32'(e.cls));
          check("pred_correct", 32'(pred_correct), 32'(e.correct));
          check("correct_count", 32'(correct_count), 32'(e.count));
          check("timeout_flag", 32'(timeout_flag), 32'(e.tflag));
          check("img_index", 32'(img_index), 32'(e.idx));
          if (e.timed_out) check("timeout_run_cycles", 32'(dv_cnt), 32'(TO));
          else check("finish_to_pred_latency", edge_seen ? 32'(cyc - edge_cyc) : '1, 32'(OD + 1));
        end
      end
      check("reset_dv_exclusive", 32'(rbm_reset & rbm_data_valid), 32'd0);
      pv_prev = pred_valid;
      if (rbm_reset) begin
        dv_cnt    = 0;
        edge_seen = 1'b0;
      end else if (rbm_data_valid) begin
        dv_cnt++;
        if (rbm_finish && !edge_seen) begin
          edge_seen = 1'b1;
          edge_cyc  = cyc;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $fatal(1);
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clock);
      n++;
    end
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_not_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic run_batch(input string name);
    int pv0;
    build_expect();
    pv0 = pv_total;
    pulse_start();
    check({name, "_busy_after_start"}, 32'(busy), 32'd1);
    wait_done(name, 2000);
    check({name, "_all_reported"}, 32'(exp_q.size()), 32'd0);
    check({name, "_strobes"}, 32'(pv_total - pv0), 32'(IN));
  endtask

  task automatic load_batch_a();
    for (int i = 0; i < IN; i++) begin
      never_fin[i] = 1'b0;
      for (int k = 0; k < OD; k++) scores[i][k] = k * 3 - 10 + i;
      scores[i][7] = 700;
    end
    labels[0] = 4'd7; labels[1] = 4'd7; labels[2] = 4'd2;
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_img_index"}, 32'(img_index), 32'd0);
    check({name, "_rbm_reset"}, 32'(rbm_reset), 32'd1);
    check({name, "_rbm_data_valid"}, 32'(rbm_data_valid), 32'd0);
    check({name, "_pred_valid"}, 32'(pred_valid), 32'd0);
    check({name, "_pred_class"}, 32'(pred_class), 32'd0);
    check({name, "_pred_correct"}, 32'(pred_correct), 32'd0);
    check({name, "_correct_count"}, 32'(correct_count), 32'd0);
    check({name, "_timeout_flag"}, 32'(timeout_flag), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int  n;
    int  pv0;
    bit  hold_ok;

    load_batch_a();
    repeat (3) @(negedge clock);
    check_reset_values("por");
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Max at class 7 on every image, labels 7,7,2.
    run_batch("batch_a");
    check("batch_a_count_literal", 32'(correct_count), 32'd2);
    check("batch_a_last_class_literal", 32'(pred_class), 32'd7);
    check("batch_a_last_correct_literal", 32'(pred_correct), 32'd0);
    check("batch_a_no_timeout", 32'(timeout_flag), 32'd0);

    // First image never finishes; its label is all-ones yet it must score as wrong.
    never_fin[0] = 1'b1;
    labels[0]    = 4'hF;
    run_batch("batch_timeout");
    check("timeout_flag_literal", 32'(timeout_flag), 32'd1);
    check("timeout_count_literal", 32'(correct_count), 32'd1);
    never_fin[0] = 1'b0;

    // Tie and signed-compare images; image store withholds the first image for 20 cycles.
    for (int k = 0; k < OD; k++) begin
      scores[0][k] = 0;
      scores[1][k] = -2048;
      scores[2][k] = 100;
    end
    scores[0][0] = 5; scores[0][1] = -3; scores[0][2] = 9; scores[0][3] = 9;
    scores[1][9] = -1;
    labels[0] = 4'd2; labels[1] = 4'd9; labels[2] = 4'd3;
    check("model_pin_tie", 32'(model_argmax(0)), 32'd2);
    check("model_pin_signed", 32'(model_argmax(1)), 32'd9);
    check("model_pin_all_equal", 32'(model_argmax(2)), 32'd0);
    build_expect();
    pv0      = pv_total;
    store_en = 1'b0;
    @(negedge clock);
    pulse_start();
    check("restart_clears_count", 32'(correct_count), 32'd0);
    check("restart_clears_timeout", 32'(timeout_flag), 32'd0);
    hold_ok = 1'b1;
    repeat (20) begin
      @(negedge clock);
      hold_ok &= rbm_reset & ~rbm_data_valid & busy;
    end
    check("load_wait_holds_core_reset", 32'(hold_ok), 32'd1);
    store_en = 1'b1;
    n        = 0;
    hold_ok  = 1'b1;
    while (!rbm_data_valid && n < 50) begin
      @(negedge clock);
      n++;
      if (!rbm_data_valid) hold_ok &= rbm_reset;
    end
    check("img_valid_to_data_valid_cycles", 32'(n), 32'(RC + 2));
    check("core_reset_before_run", 32'(hold_ok), 32'd1);
    wait_done("batch_b", 2000);
    check("batch_b_all_reported", 32'(exp_q.size()), 32'd0);
    check("batch_b_strobes", 32'(pv_total - pv0), 32'(IN));
    check("batch_b_count_literal", 32'(correct_count), 32'd2);

    // rbm_finish stuck high the whole batch: one capture per image.
    for (int k = 0; k < OD; k++) begin
      scores[0][k] = k * k - 20;
      scores[1][k] = 50 - k;
      scores[2][k] = -k * 100;
    end
    scores[0][3] = 900;
    scores[1][5] = 300;
    labels[0] = 4'd3; labels[1] = 4'd4; labels[2] = 4'd0;
    stuck = 1'b1;
    repeat (2) @(negedge clock);
    run_batch("batch_stuck");
    check("batch_stuck_count_literal", 32'(correct_count), 32'd2);
    stuck = 1'b0;
    repeat (2) @(negedge clock);

    // Async reset in the argmax of the second image: only the first image may report.
    load_batch_a();
    build_expect();
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    pulse_start();
    n = 0;
    while (!(img_index == 16'd1 && edge_seen) && n < 500) begin
      @(negedge clock);
      n++;
    end
    check("reached_second_image_finish", 32'(img_index == 16'd1 && edge_seen), 32'd1);
    repeat (3) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("mid_argmax_reset");
    check("first_image_reported_before_reset", 32'(exp_q.size()), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    pv0   = pv_total;
    repeat (30) @(negedge clock);
    check("no_strobe_after_reset", 32'(pv_total - pv0), 32'd0);
    run_batch("batch_rerun");
    check("batch_rerun_count_literal", 32'(correct_count), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
